// File: rtl/rv32_mod_fetch_aligner_if.sv
// Bundle of the aligner's bus signals.
//   imem_req_*    : word fetch request to instruction memory
//   imem_resp_*   : single-cycle read response from instruction memory
//   redirect_*    : control-flow redirect from the back end
//   instr_*       : realigned instruction stream towards the decoder
// The master modport is the aligner, the slave modport is its surroundings.
interface rv32_mod_fetch_aligner_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_is_compressed;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr, instr_pc, instr_is_compressed,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr, instr_pc, instr_is_compressed,
    output instr_ready
  );
endinterface

// File: rtl/rv32_mod_fetch_aligner.sv
// RV32IMC instruction fetch and alignment stage.
// Fetches 32-bit words, splits them into halfwords in a 3-entry queue and
// emits one complete 16-bit or 32-bit instruction per decoder handshake,
// together with its PC. Redirects flush everything and restart fetch.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : rv32_mod_fetch_aligner_if.master (imem request/response,
//              redirect, instruction output)
module rv32_mod_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                             clk,
  input  logic                             rst,
  rv32_mod_fetch_aligner_if.master         bus
);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t      state;
  logic [1:0]  count;
  logic [47:0] hwq;          // hw[0] in [15:0], hw[1] in [31:16], hw[2] in [47:32]
  logic [31:0] fetch_addr;
  logic [31:0] head_pc;
  logic        drop_low;
  logic        discard;

  logic        vld_p1;
  logic [31:0] instr_p1;
  logic [31:0] pc_p1;
  logic        cmp_p1;

  logic        req_valid;
  logic        accept;
  logic        push_en;
  logic [1:0]  push_n;
  logic [31:0] push_data;
  logic [47:0] keep;
  logic [47:0] mq;
  logic [2:0]  avail;
  logic        out_load;
  logic [1:0]  pop_n;
  logic [1:0]  count_n;

  always_comb begin
    req_valid = (state == S_REQ) && (count <= 2'd1);
    accept    = req_valid && bus.imem_req_ready;
    push_en   = (state == S_WAIT) && bus.imem_resp_valid && !discard;

    push_n    = 2'd0;
    push_data = 32'h0;
    if (push_en) begin
      if (drop_low) begin
        push_n    = 2'd1;
        push_data = {16'h0, bus.imem_resp_data[31:16]};
      end else begin
        push_n    = 2'd2;
        push_data = bus.imem_resp_data;
      end
    end

    // Merged view of queue plus incoming halfwords, so a response can feed
    // the output register in the same edge it arrives. Stale entries above
    // count are masked off. count <= 1 whenever a response is pushed, so
    // the merged view never exceeds three halfwords.
    keep  = ~(48'hFFFF_FFFF_FFFF << {count, 4'b0000});
    mq    = (hwq & keep) | ({16'h0, push_data} << {count, 4'b0000});
    avail = {1'b0, count} + {1'b0, push_n};

    out_load = !vld_p1 || bus.instr_ready;
    pop_n    = 2'd0;
    if (out_load) begin
      if ((avail >= 3'd1) && (mq[1:0] != 2'b11)) pop_n = 2'd1;
      else if (avail >= 3'd2)                    pop_n = 2'd2;
    end
    count_n = count + push_n - pop_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      count      <= 2'd0;
      fetch_addr <= {RESET_PC[31:2], 2'b00};
      head_pc    <= {RESET_PC[31:1], 1'b0};
      drop_low   <= RESET_PC[1];
      discard    <= 1'b0;
      vld_p1     <= 1'b0;
      instr_p1   <= 32'h0;
      pc_p1      <= 32'h0;
      cmp_p1     <= 1'b0;
    end else if (bus.redirect_valid) begin
      count      <= 2'd0;
      vld_p1     <= 1'b0;
      fetch_addr <= bus.redirect_pc & 32'hFFFF_FFFC;
      head_pc    <= bus.redirect_pc & 32'hFFFF_FFFE;
      drop_low   <= bus.redirect_pc[1];
      // A request is still outstanding if we were waiting without a
      // response this cycle, or one is being accepted right now. If the
      // outstanding response lands in this very cycle nothing is in
      // flight afterwards, so waiting for another one would hang.
      if (((state == S_WAIT) && !bus.imem_resp_valid) || accept) begin
        discard <= (state == S_WAIT) ? (discard | 1'b1) : 1'b1;
        state   <= S_WAIT;
      end else begin
        discard <= 1'b0;
        state   <= S_REQ;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (accept) begin
            state      <= S_WAIT;
            fetch_addr <= fetch_addr + 32'd4;
          end
        end
        S_WAIT: begin
          if (bus.imem_resp_valid) begin
            state <= S_REQ;
            if (discard)       discard  <= 1'b0;
            else if (drop_low) drop_low <= 1'b0;
          end
        end
        default: state <= S_REQ;
      endcase

      hwq   <= mq >> {pop_n, 4'b0000};
      count <= count_n;

      // output stage (p1)
      if (out_load) begin
        if (pop_n != 2'd0) begin
          vld_p1   <= 1'b1;
          instr_p1 <= (pop_n == 2'd1) ? {16'h0, mq[15:0]} : mq[31:0];
          pc_p1    <= head_pc;
          cmp_p1   <= (pop_n == 2'd1);
          head_pc  <= head_pc + ((pop_n == 2'd1) ? 32'd2 : 32'd4);
        end else begin
          vld_p1   <= 1'b0;
        end
      end
    end
  end

  assign bus.imem_req_valid      = req_valid;
  assign bus.imem_req_addr       = fetch_addr;
  assign bus.instr_valid         = vld_p1;
  assign bus.instr               = instr_p1;
  assign bus.instr_pc            = pc_p1;
  assign bus.instr_is_compressed = cmp_p1;

endmodule

// File: tb/tb_rv32_mod_fetch_aligner.sv
module tb_rv32_mod_fetch_aligner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  rv32_mod_fetch_aligner_if bus();

  rv32_mod_fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.instr_ready     = 1'b1;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Accept one request (bounded wait) and answer it one cycle later.
  task automatic serve(input logic [31:0] w);
    int n = 0;
    while (bus.imem_req_valid !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    total++;
    if (bus.imem_req_valid !== 1'b1) begin
      bad++;
      $display("FAIL serve_req_timeout got=%b want=1", bus.imem_req_valid);
    end
    bus.imem_req_ready = 1'b1;
    cyc();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = w;
    cyc();
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.imem_req_valid !== 1'b1) begin bad++; $display("FAIL rst_req_valid got=%b want=1", bus.imem_req_valid); end
    total++; if (bus.imem_req_addr !== 32'h0) begin bad++; $display("FAIL rst_req_addr got=%h want=0", bus.imem_req_addr); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rst_instr_valid got=%b want=0", bus.instr_valid); end
    total++; if (bus.instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", bus.instr); end
    total++; if (bus.instr_pc !== 32'h0) begin bad++; $display("FAIL rst_instr_pc got=%h want=0", bus.instr_pc); end
    total++; if (bus.instr_is_compressed !== 1'b0) begin bad++; $display("FAIL rst_cmp got=%b want=0", bus.instr_is_compressed); end
  endtask

  task automatic test_stream32();
    do_reset();
    serve(32'h0050_0093);
    total++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h0050_0093 || bus.instr_pc !== 32'h0 || bus.instr_is_compressed !== 1'b0) begin
      bad++; $display("FAIL s32_first got=%b/%h/%h/%b want=1/00500093/0/0", bus.instr_valid, bus.instr, bus.instr_pc, bus.instr_is_compressed); end
    serve(32'h00A0_0113);
    total++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h00A0_0113 || bus.instr_pc !== 32'h4 || bus.instr_is_compressed !== 1'b0) begin
      bad++; $display("FAIL s32_second got=%b/%h/%h/%b want=1/00a00113/4/0", bus.instr_valid, bus.instr, bus.instr_pc, bus.instr_is_compressed); end
    total++; if (bus.imem_req_addr !== 32'h8) begin bad++; $display("FAIL s32_next_addr got=%h want=8", bus.imem_req_addr); end
  endtask

  task automatic test_mixed_span();
    do_reset();
    serve(32'h0093_4505);
    total++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h0000_4505 || bus.instr_pc !== 32'h0 || bus.instr_is_compressed !== 1'b1) begin
      bad++; $display("FAIL mix_c_li got=%b/%h/%h/%b want=1/00004505/0/1", bus.instr_valid, bus.instr, bus.instr_pc, bus.instr_is_compressed); end
    cyc();
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL mix_span_wait got=%b want=0", bus.instr_valid); end
    serve(32'h4505_0050);
    total++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h0050_0093 || bus.instr_pc !== 32'h2 || bus.instr_is_compressed !== 1'b0) begin
      bad++; $display("FAIL mix_span got=%b/%h/%h/%b want=1/00500093/2/0", bus.instr_valid, bus.instr, bus.instr_pc, bus.instr_is_compressed); end
    cyc();
    total++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h0000_4505 || bus.instr_pc !== 32'h6) begin
      bad++; $display("FAIL mix_tail got=%b/%h/%h want=1/00004505/6", bus.instr_valid, bus.instr, bus.instr_pc); end
  endtask

  task automatic test_redirect_odd();
    do_reset();
    bus.imem_req_ready = 1'b1;
    cyc();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0102;
    cyc();
    bus.redirect_valid = 1'b0;
    total++; if (bus.instr_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL rdo_pending got=%b/%b want=0/0", bus.instr_valid, bus.imem_req_valid); end
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'hDEAD_BEEF;
    cyc();
    bus.imem_resp_valid = 1'b0;
    total++; if (bus.instr_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin
      bad++; $display("FAIL rdo_discard got=%b/%b/%h want=0/1/00000100", bus.instr_valid, bus.imem_req_valid, bus.imem_req_addr); end
    serve(32'h4585_1234);
    total++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h0000_4585 || bus.instr_pc !== 32'h102 || bus.instr_is_compressed !== 1'b1) begin
      bad++; $display("FAIL rdo_out got=%b/%h/%h/%b want=1/00004585/102/1", bus.instr_valid, bus.instr, bus.instr_pc, bus.instr_is_compressed); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_i [3];
    exp_i[0] = 32'h0000_4585;
    exp_i[1] = 32'h0000_0001;
    exp_i[2] = 32'h0000_8082;
    do_reset();
    bus.instr_ready = 1'b0;
    serve(32'h4585_4505);
    total++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h0000_4505 || bus.instr_pc !== 32'h0) begin
      bad++; $display("FAIL bp_first got=%b/%h/%h want=1/00004505/0", bus.instr_valid, bus.instr, bus.instr_pc); end
    serve(32'h8082_0001);
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_full_noreq got=%b want=0", bus.imem_req_valid); end
    for (int i = 0; i < 5; i++) begin
      cyc();
      total++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h0000_4505 || bus.instr_pc !== 32'h0 || bus.imem_req_valid !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d got=%b/%h/%h/%b want=1/00004505/0/0", i, bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_req_valid); end
    end
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (bus.instr_valid !== 1'b1 || bus.instr !== exp_i[i] || bus.instr_pc !== 32'(2 * (i + 1))) begin
        bad++; $display("FAIL bp_drain%0d got=%b/%h/%h want=1/%h/%h", i, bus.instr_valid, bus.instr, bus.instr_pc, exp_i[i], 32'(2 * (i + 1))); end
    end
    cyc();
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%b want=0", bus.instr_valid); end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    serve(32'h00A0_0113);
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    cyc();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    total++; if (bus.instr_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL rsc_flush got=%b/%b want=0/0", bus.instr_valid, bus.imem_req_valid); end
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h0050_0093;
    cyc();
    bus.imem_resp_valid = 1'b0;
    total++; if (bus.instr_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h200) begin
      bad++; $display("FAIL rsc_stale got=%b/%b/%h want=0/1/00000200", bus.instr_valid, bus.imem_req_valid, bus.imem_req_addr); end
    serve(32'h0030_0193);
    total++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h0030_0193 || bus.instr_pc !== 32'h200) begin
      bad++; $display("FAIL rsc_resume got=%b/%h/%h want=1/00300193/200", bus.instr_valid, bus.instr, bus.instr_pc); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    serve(32'h0050_0093);
    bus.imem_req_ready = 1'b1;
    cyc();
    bus.imem_req_ready = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h00A0_0113;
    cyc();
    bus.imem_resp_valid = 1'b0;
    total++; if (bus.instr_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
      bad++; $display("FAIL mrst_late got=%b/%b/%h want=0/1/0", bus.instr_valid, bus.imem_req_valid, bus.imem_req_addr); end
    cyc();
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL mrst_quiet got=%b want=0", bus.instr_valid); end
    serve(32'h0030_0193);
    total++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h0030_0193 || bus.instr_pc !== 32'h0) begin
      bad++; $display("FAIL mrst_first got=%b/%h/%h want=1/00300193/0", bus.instr_valid, bus.instr, bus.instr_pc); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    cyc();
    bus.redirect_valid = 1'b0;
    total++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_req got=%b/%h want=1/fffffffc", bus.imem_req_valid, bus.imem_req_addr); end
    serve(32'h0050_0093);
    total++; if (bus.instr !== 32'h0050_0093 || bus.instr_pc !== 32'hFFFF_FFFC || bus.imem_req_addr !== 32'h0) begin
      bad++; $display("FAIL wrap_top got=%h/%h/%h want=00500093/fffffffc/0", bus.instr, bus.instr_pc, bus.imem_req_addr); end
    serve(32'h00A0_0113);
    total++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h00A0_0113 || bus.instr_pc !== 32'h0) begin
      bad++; $display("FAIL wrap_zero got=%b/%h/%h want=1/00a00113/0", bus.instr_valid, bus.instr, bus.instr_pc); end
  endtask

  initial begin
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.instr_ready     = 1'b1;
    test_reset();
    test_stream32();
    test_mixed_span();
    test_redirect_odd();
    test_backpressure();
    test_redirect_same_cycle();
    test_mid_reset();
    test_pc_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
